draw_fade: RTL and testbench

DRAW_FADE -- requirements
Module: draw_fade

---
 rtl/draw_fade_if.sv | 13 +
 rtl/draw_fade.sv | 173 +++++++++++++++++
 tb/tb_draw_fade.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/draw_fade_if.sv
// VGA timing plus 12-bit rgb stream bundle shared between drawing stages.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_fade.sv
// Screen fade stage: delays the vga stream by one clock and scales rgb by a
// 0..16 intensity that steps once per STEP_FRAMES frames through
// fade-out, a black hold of HOLD_FRAMES frames, and fade-in.
module draw_fade #(
    parameter int unsigned STEP_FRAMES = 4,
    parameter int unsigned HOLD_FRAMES = 60
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     start,
    vga_if.in        in,
    vga_if.out       out,
    output logic     busy,
    output logic     dark
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_OUT = 2'd1,
        HOLD     = 2'd2,
        FADE_IN  = 2'd3
    } state_t;

    localparam logic [4:0] LEVEL_FULL = 5'd16;
    localparam logic [7:0] STEP_LAST  = 8'(STEP_FRAMES - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(HOLD_FRAMES - 1);

    state_t      state_q, state_d;
    logic [4:0]  level_q, level_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        vsync_hist_q, vsync_hist_d;
    logic        tick;

    logic [10:0] hcount_q, hcount_d;
    logic [10:0] vcount_q, vcount_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        hblnk_q, hblnk_d;
    logic        vblnk_q, vblnk_d;
    logic [11:0] rgb_q, rgb_d;

    // One colour channel scaled by level; the 9-bit product keeps 15*16 exact.
    function automatic logic [3:0] scale_ch(input logic [3:0] ch, input logic [4:0] lvl);
        logic [8:0] prod;
        prod = {5'd0, ch} * {4'd0, lvl};
        return 4'(prod >> 4);
    endfunction

    assign tick = in.vsync & ~vsync_hist_q;

    // Fade sequencer: next state, level and frame counter, advanced only on frame ticks.
    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        cnt_d        = cnt_q;
        vsync_hist_d = in.vsync;
        unique case (state_q)
            IDLE: begin
                level_d = LEVEL_FULL;
                cnt_d   = '0;
                // A tick coinciding with start is deliberately not counted.
                if (start) begin
                    state_d = FADE_OUT;
                end
            end
            FADE_OUT: begin
                if (tick) begin
                    if (cnt_q == STEP_LAST) begin
                        cnt_d   = '0;
                        level_d = level_q - 5'd1;
                        if (level_q == 5'd1) begin
                            state_d = HOLD;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_d   = '0;
                        state_d = FADE_IN;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            FADE_IN: begin
                if (tick) begin
                    if (cnt_q == STEP_LAST) begin
                        cnt_d   = '0;
                        level_d = level_q + 5'd1;
                        if (level_q == 5'd15) begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                level_d = LEVEL_FULL;
                cnt_d   = '0;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            level_q      <= LEVEL_FULL;
            cnt_q        <= '0;
            vsync_hist_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            cnt_q        <= cnt_d;
            vsync_hist_q <= vsync_hist_d;
        end
    end

    // Output stream: timing copied through, rgb scaled and forced black in blanking.
    always_comb begin
        hcount_d = in.hcount;
        vcount_d = in.vcount;
        hsync_d  = in.hsync;
        vsync_d  = in.vsync;
        hblnk_d  = in.hblnk;
        vblnk_d  = in.vblnk;
        rgb_d    = '0;
        if (!(in.hblnk || in.vblnk)) begin
            rgb_d = {scale_ch(in.rgb[11:8], level_q),
                     scale_ch(in.rgb[7:4],  level_q),
                     scale_ch(in.rgb[3:0],  level_q)};
        end
    end

    // Output stream registers, one clock of latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount_q <= '0;
            vcount_q <= '0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            hblnk_q  <= 1'b0;
            vblnk_q  <= 1'b0;
            rgb_q    <= '0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            hblnk_q  <= hblnk_d;
            vblnk_q  <= vblnk_d;
            rgb_q    <= rgb_d;
        end
    end

    assign out.hcount = hcount_q;
    assign out.vcount = vcount_q;
    assign out.hsync  = hsync_q;
    assign out.vsync  = vsync_q;
    assign out.hblnk  = hblnk_q;
    assign out.vblnk  = vblnk_q;
    assign out.rgb    = rgb_q;

    assign busy = (state_q != IDLE);
    assign dark = (state_q == HOLD);

endmodule

// File: tb/tb_draw_fade.sv
// Directed bench for draw_fade with STEP_FRAMES=2, HOLD_FRAMES=3.
module tb_draw_fade;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy, dark;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    vga_if vin ();
    vga_if vout ();

    draw_fade #(.STEP_FRAMES(2), .HOLD_FRAMES(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in    (vin),
        .out   (vout),
        .busy  (busy),
        .dark  (dark)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] hc;
        logic [10:0] vc;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
        logic [11:0] exp_rgb;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One frame: vsync high 1 cycle (the tick), then low 2 cycles.
    task automatic frame();
        vin.vsync = 1'b1;
        step();
        vin.vsync = 1'b0;
        step();
        step();
    endtask

    // Expected level after k counted ticks of a sequence (STEP=2, HOLD=3).
    function automatic int exp_level(input int k);
        if (k <= 32) return 16 - k / 2;
        if (k <= 35) return 0;
        return (k - 35) / 2;
    endfunction

    function automatic logic [11:0] exp_white(input int lvl);
        logic [3:0] c;
        c = 4'((15 * lvl) >> 4);
        return {c, c, c};
    endfunction

    task automatic run_seq(input bit coincide, input bit extra_starts);
        vin.rgb = 12'hFFF; vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.vsync = 1'b0;
        step();
        start = 1'b1;
        if (coincide) vin.vsync = 1'b1;
        step();
        start = 1'b0;
        vin.vsync = 1'b0;
        step();
        chk("seq_busy_after_start", busy, 1'b1);
        chk("seq_rgb_after_start", vout.rgb, 12'hFFF);
        step();
        for (int k = 1; k <= 67; k++) begin
            frame();
            chk($sformatf("seq_rgb_k%0d", k), vout.rgb, exp_white(exp_level(k)));
            chk($sformatf("seq_busy_k%0d", k), busy, (k < 67));
            chk($sformatf("seq_dark_k%0d", k), dark, (k >= 32 && k < 35));
            if (extra_starts && (k == 10 || k == 33)) begin
                start = 1'b1;
                step();
                start = 1'b0;
            end
        end
    endtask

    initial begin
        vecs[0] = '{11'd100,  11'd20,   1'b0, 1'b0, 1'b0, 1'b0, 12'hABC, 12'hABC};
        vecs[1] = '{11'd639,  11'd479,  1'b1, 1'b0, 1'b0, 1'b0, 12'h123, 12'h123};
        vecs[2] = '{11'd700,  11'd10,   1'b0, 1'b0, 1'b1, 1'b0, 12'hFFF, 12'h000};
        vecs[3] = '{11'd5,    11'd500,  1'b0, 1'b1, 1'b0, 1'b1, 12'hFFF, 12'h000};
        vecs[4] = '{11'd0,    11'd0,    1'b1, 1'b1, 1'b1, 1'b1, 12'h5A5, 12'h000};
        vecs[5] = '{11'd2047, 11'd2047, 1'b1, 1'b0, 1'b0, 1'b0, 12'hF0F, 12'hF0F};
        vecs[6] = '{11'd10,   11'd10,   1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000};

        // Reset state with non-zero inputs present.
        vin.hcount = 11'd123; vin.vcount = 11'd45; vin.hsync = 1'b1; vin.vsync = 1'b0;
        vin.hblnk = 1'b1; vin.vblnk = 1'b1; vin.rgb = 12'hFFF;
        step(); step();
        chk("rst_hcount", vout.hcount, 11'd0);
        chk("rst_hsync", vout.hsync, 1'b0);
        chk("rst_hblnk", vout.hblnk, 1'b0);
        chk("rst_rgb", vout.rgb, 12'h000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_dark", dark, 1'b0);
        rst = 1'b0;
        step();

        // Passthrough and blanking vectors at full brightness.
        for (int i = 0; i < 7; i++) begin
            vin.hcount = vecs[i].hc; vin.vcount = vecs[i].vc;
            vin.hsync = vecs[i].hs; vin.vsync = vecs[i].vs;
            vin.hblnk = vecs[i].hb; vin.vblnk = vecs[i].vb;
            vin.rgb = vecs[i].rgb;
            step();
            chk($sformatf("vec%0d_hcount", i), vout.hcount, vecs[i].hc);
            chk($sformatf("vec%0d_vcount", i), vout.vcount, vecs[i].vc);
            chk($sformatf("vec%0d_hsync", i), vout.hsync, vecs[i].hs);
            chk($sformatf("vec%0d_vsync", i), vout.vsync, vecs[i].vs);
            chk($sformatf("vec%0d_hblnk", i), vout.hblnk, vecs[i].hb);
            chk($sformatf("vec%0d_vblnk", i), vout.vblnk, vecs[i].vb);
            chk($sformatf("vec%0d_rgb", i), vout.rgb, vecs[i].exp_rgb);
            chk($sformatf("vec%0d_busy", i), busy, 1'b0);
        end

        // Full sequence, then one with coincident start/tick and ignored starts.
        run_seq(1'b0, 1'b0);
        run_seq(1'b1, 1'b1);

        // Mid-fade reset at level 8.
        vin.hsync = 1'b1; vin.hcount = 11'd321;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        for (int k = 1; k <= 16; k++) frame();
        chk("mid_rgb_level8", vout.rgb, 12'h777);
        chk("mid_busy", busy, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_rst_rgb", vout.rgb, 12'h000);
        chk("async_rst_hsync", vout.hsync, 1'b0);
        chk("async_rst_hcount", vout.hcount, 11'd0);
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_dark", dark, 1'b0);
        step();
        rst = 1'b0;
        step(); step();
        chk("post_rst_rgb", vout.rgb, 12'hFFF);
        chk("post_rst_hcount", vout.hcount, 11'd321);
        chk("post_rst_busy", busy, 1'b0);
        frame();
        chk("post_rst_rgb_after_tick", vout.rgb, 12'hFFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
